// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: cycle, stall, flush and retire counters for the 5-stage
// pipeline. Counting is gated by a small IDLE/RUN/DONE run-length FSM, and
// the counters are read back through a one-cycle request/response port.
// start_i doubles as the asynchronous active-low reset of the whole block.
module pipe_perf_monitor #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 15
) (
  input  logic             clk_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             clear_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             done_o,
  output logic             running_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A zero run length means the monitor never leaves RUN on its own.
  localparam bit               LIMITED = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Saturating increment: the counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic inc);
    logic [CNT_W-1:0] r;
    if (inc && (v != CNT_MAX)) begin
      r = v + CNT_ONE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             running_q, running_d;
  logic [CNT_W-1:0] cycle_inc_s;
  logic [CNT_W-1:0] rd_mux_s;

  // Next-state and counter update; clear overrides counting and the DONE transition.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    stall_d     = stall_q;
    flush_d     = flush_q;
    retire_d    = retire_q;
    cycle_inc_s = sat_inc(cycle_q, 1'b1);
    if (clear_i) begin
      state_d  = ST_IDLE;
      cycle_d  = CNT_ZERO;
      stall_d  = CNT_ZERO;
      flush_d  = CNT_ZERO;
      retire_d = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Out of reset (or clear) start_i is high, so the next edge enters RUN.
          state_d = ST_RUN;
        end
        ST_RUN: begin
          cycle_d  = cycle_inc_s;
          // A stall raised alongside a branch decode is a control hazard, not a data stall.
          stall_d  = sat_inc(stall_q, stall_i & ~branch_i);
          flush_d  = sat_inc(flush_q, flush_i);
          retire_d = sat_inc(retire_q, retire_i);
          if (LIMITED && (cycle_inc_s == MAX_C)) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    done_d    = (state_d == ST_DONE);
    running_d = (state_d == ST_RUN);
  end

  // Read mux and response capture; the response samples pre-update counter values.
  always_comb begin
    case (rd_sel_i)
      2'd0:    rd_mux_s = cycle_q;
      2'd1:    rd_mux_s = stall_q;
      2'd2:    rd_mux_s = flush_q;
      2'd3:    rd_mux_s = retire_q;
      default: rd_mux_s = CNT_ZERO;
    endcase
    if (rd_req_i) begin
      rd_data_d = rd_mux_s;
    end else begin
      rd_data_d = rd_data_q;
    end
    rd_valid_d = rd_req_i;
  end

  // State, counter and read-port registers, all cleared asynchronously by start_i.
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_q    <= ST_IDLE;
      cycle_q    <= CNT_ZERO;
      stall_q    <= CNT_ZERO;
      flush_q    <= CNT_ZERO;
      retire_q   <= CNT_ZERO;
      rd_data_q  <= CNT_ZERO;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      retire_q   <= retire_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      running_q  <= running_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign done_o     = done_q;
  assign running_o  = running_q;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Self-checking bench for pipe_perf_monitor. Two instances share stimulus:
// the default build (32-bit, run length 15) and a 4-bit unlimited build that
// exercises saturation. A behavioural model keeps true event counts and
// saturates them only when they are observed.
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        start_i = 1'b1;
  logic        stall_i = 1'b0, branch_i = 1'b0, flush_i = 1'b0, retire_i = 1'b0;
  logic        clear_i = 1'b0, rd_req_i = 1'b0;
  logic [1:0]  rd_sel_i = 2'd0;
  logic [31:0] rd_data_a;
  logic [3:0]  rd_data_b;
  logic        rd_valid_a, done_a, running_a;
  logic        rd_valid_b, done_b, running_b;

  int vectors = 0;
  int miscompares = 0;

  pipe_perf_monitor #(.CNT_W(32), .MAX_CYCLES(15)) dut (
    .clk_i(clk), .start_i(start_i), .stall_i(stall_i), .branch_i(branch_i),
    .flush_i(flush_i), .retire_i(retire_i), .clear_i(clear_i),
    .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .done_o(done_a), .running_o(running_a));

  pipe_perf_monitor #(.CNT_W(4), .MAX_CYCLES(0)) dut_sat (
    .clk_i(clk), .start_i(start_i), .stall_i(stall_i), .branch_i(branch_i),
    .flush_i(flush_i), .retire_i(retire_i), .clear_i(clear_i),
    .rd_req_i(rd_req_i), .rd_sel_i(rd_sel_i), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .done_o(done_b), .running_o(running_b));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          wid [2] = '{32, 4};
  int          maxc[2] = '{15, 0};
  longint      cnt [2][4];        // true (unsaturated) cycle/stall/flush/retire
  bit          m_run[2], m_done[2];
  logic [31:0] exp_data[2];
  bit          exp_valid[2];

  function automatic logic [31:0] satv(input int w, input longint v);
    longint lim;
    lim = (longint'(1) << w) - 1;
    if (v > lim) v = lim;
    return v[31:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 4; k++) cnt[i][k] = 0;
      m_run[i] = 0; m_done[i] = 0;
      exp_data[i] = 32'd0; exp_valid[i] = 0;
    end
  endtask

  // One rising edge worth of behaviour, using the inputs currently applied.
  task automatic model_edge();
    if (start_i) begin
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = rd_req_i;
        if (rd_req_i) exp_data[i] = satv(wid[i], cnt[i][rd_sel_i]);
        if (clear_i) begin
          for (int k = 0; k < 4; k++) cnt[i][k] = 0;
          m_run[i] = 0; m_done[i] = 0;
        end else if (!m_run[i] && !m_done[i]) begin
          m_run[i] = 1;
        end else if (m_run[i]) begin
          cnt[i][0] += 1;
          cnt[i][1] += (stall_i && !branch_i) ? 1 : 0;
          cnt[i][2] += flush_i ? 1 : 0;
          cnt[i][3] += retire_i ? 1 : 0;
          if (maxc[i] != 0 && satv(wid[i], cnt[i][0]) == 32'(maxc[i])) begin
            m_run[i] = 0; m_done[i] = 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("done_a",    {31'd0, done_a},     {31'd0, m_done[0]});
    chk("running_a", {31'd0, running_a},  {31'd0, m_run[0]});
    chk("valid_a",   {31'd0, rd_valid_a}, {31'd0, exp_valid[0]});
    chk("data_a",    rd_data_a,           exp_data[0]);
    chk("done_b",    {31'd0, done_b},     {31'd0, m_done[1]});
    chk("running_b", {31'd0, running_b},  {31'd0, m_run[1]});
    chk("valid_b",   {31'd0, rd_valid_b}, {31'd0, exp_valid[1]});
    chk("data_b",    {28'd0, rd_data_b},  exp_data[1]);
  endtask

  // Apply current inputs across one posedge, then compare #1 after it.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic set_in(input logic s, input logic b, input logic f, input logic r,
                        input logic c, input logic q, input logic [1:0] sel);
    stall_i = s; branch_i = b; flush_i = f; retire_i = r;
    clear_i = c; rd_req_i = q; rd_sel_i = sel;
  endtask

  task automatic read(input logic [1:0] sel);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, sel);
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    model_reset();
    // Async reset before any clock edge.
    #2 start_i = 1'b0;
    #1;
    model_reset();
    check_model();
    chk("rst_data_a", rd_data_a, 32'd0);
    repeat (2) tick();

    // Run length: release, all strobes low, DONE after 16 edges.
    start_i = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (15) tick();
    chk("done_before_16", {31'd0, done_a}, 32'd0);
    tick();
    chk("done_at_16", {31'd0, done_a}, 32'd1);
    repeat (4) tick();
    read(2'd0); chk("runlen_cycle", rd_data_a, 32'd15);
    read(2'd1); chk("runlen_stall", rd_data_a, 32'd0);
    read(2'd2); chk("runlen_flush", rd_data_a, 32'd0);
    read(2'd3); chk("runlen_retire", rd_data_a, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (3) tick();
    chk("data_hold", rd_data_a, 32'd0);
    read(2'd0); chk("cycle_stays_15", rd_data_a, 32'd15);

    // Stall qualification.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    for (int k = 0; k < 7; k++) begin
      set_in(k < 4, (k == 1) || (k == 3), (k == 0) || (k == 2), 1'b1, 1'b0, 1'b0, 2'd0);
      tick();
    end
    read(2'd0); chk("b2b_cycle", rd_data_a, 32'd7);
    chk("b2b_valid0", {31'd0, rd_valid_a}, 32'd1);
    read(2'd1); chk("b2b_stall", rd_data_a, 32'd2);
    read(2'd2); chk("b2b_flush", rd_data_a, 32'd2);
    read(2'd3); chk("b2b_retire", rd_data_a, 32'd7);
    chk("b2b_valid3", {31'd0, rd_valid_a}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    chk("valid_drops", {31'd0, rd_valid_a}, 32'd0);

    // Read coincident with the 5->6 cycle increment.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    repeat (5) tick();
    read(2'd0); chk("read_pre_update", rd_data_a, 32'd5);

    // Clear mid-run together with a read.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    repeat (7) tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0); tick();
    chk("clear_read", rd_data_a, 32'd7);
    chk("clear_idle", {31'd0, running_a}, 32'd0);
    read(2'd0);
    chk("clear_cycle0", rd_data_a, 32'd0);
    chk("clear_rerun", {31'd0, running_a}, 32'd1);
    read(2'd3);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (3) tick();
    chk("clear_no_done", {31'd0, done_a}, 32'd0);

    // Saturation on the 4-bit unlimited instance.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    repeat (20) tick();
    read(2'd0); chk("sat_cycle", {28'd0, rd_data_b}, 32'd15);
    read(2'd3); chk("sat_retire", {28'd0, rd_data_b}, 32'd15);
    chk("sat_no_done", {31'd0, done_b}, 32'd0);

    // Randomized traffic with occasional clears.
    for (int n = 0; n < 300; n++) begin
      set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom_range(0, 39) == 0, 1'($urandom), 2'($urandom));
      tick();
    end

    // Asynchronous reset while a response is on the port.
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0); tick();
    read(2'd0);
    chk("pre_rst_valid", {31'd0, rd_valid_a}, 32'd1);
    #2 start_i = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {31'd0, rd_valid_a}, 32'd0);
    chk("arst_data", rd_data_a, 32'd0);
    chk("arst_running", {31'd0, running_a}, 32'd0);
    check_model();
    repeat (2) tick();
    start_i = 1'b1;
    for (int s = 0; s < 4; s++) begin
      read(2'(s));
      chk("arst_cnt_zero", rd_data_a, 32'd0);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
